axi4_master: RTL and testbench
==============================

# axi4_master

AXI4 initiator that turns single-transaction commands into AXI4 INCR bursts on the AW/W/B and AR/R channels. It is the counterpart of the team's `axi4` memory responder and drives the same signal set: no WSTRB, no IDs, no locks. It sits between a simple command/stream front end (a test sequencer or a DMA-style client) and the `axi4_if` bus. It runs one transaction at a time, and write-address, write-data and response phases are strictly sequential.

## Interface
- DATA_WIDTH, 32: data bus width in bits; AWSIZE/ARSIZE = log2(DATA_WIDTH/8).
- ADDR_WIDTH, 16: byte address width.
- ACLK  in  1: clock; all logic on the rising edge.
- ARESET  in  1: asynchronous, active-high reset.
- cmd_valid  in  1 / cmd_ready  out  1: command handshake.
- cmd_write  in  1: 1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH: start byte address, word aligned.
- cmd_len  in  8: AXI length; beats = cmd_len+1.
- wd_data  in  DATA_WIDTH / wd_valid  in  1 / wd_ready  out  1: write-data stream.
- rd_data  out  DATA_WIDTH / rd_valid  out  1 / rd_last  out  1 / rd_ready  in  1: read-data stream.
- done  out  1: one-cycle completion pulse.
- done_resp  out  2: final response (BRESP, or worst RRESP).
- len_err  out  1: qualifies done; RLAST/beat-count mismatch.
- AWADDR  out  ADDR_WIDTH, AWLEN  out  8, AWSIZE  out  3, AWVALID  out  1, AWREADY  in  1.
- WDATA  out  DATA_WIDTH, WVALID  out  1, WLAST  out  1, WREADY  in  1.
- BRESP  in  2, BVALID  in  1, BREADY  out  1.
- ARADDR  out  ADDR_WIDTH, ARLEN  out  8, ARSIZE  out  3, ARVALID  out  1, ARREADY  in  1.
- RDATA  in  DATA_WIDTH, RRESP  in  2, RVALID  in  1, RLAST  in  1, RREADY  out  1.

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, register addr, len and write flag. Clear the beat counter and the response accumulator. Go to AW if write, else AR.
- AW: AWVALID=1 with registered AWADDR/AWLEN. AWSIZE is constant. On AWREADY, go to W.
- W: WDATA=wd_data, WVALID=wd_valid and wd_ready=WREADY, all combinational pass-through and gated by state. WLAST=1 when beat counter == len. Each WVALID&WREADY increments the counter. The beat with WLAST goes to B.
- B: BREADY=1. On BVALID, capture BRESP and go to DONE.
- AR: ARVALID=1 with registered ARADDR/ARLEN. On ARREADY, go to R.
- R: rd_data=RDATA, rd_valid=RVALID, RREADY=rd_ready, rd_last=RLAST, all gated by state.
  - Each RVALID&RREADY increments the counter.
  - The response accumulator keeps the numerically largest RRESP seen.
  - Length error: RLAST on a beat with counter != len, or RLAST=0 on the beat with counter == len. Either sets a sticky error flag.
  - Exit to DONE on the beat with RLAST=1 or the beat with counter == len, whichever comes first.
- DONE: done=1 for exactly one cycle, with done_resp and len_err valid in that cycle. Return to IDLE.
- Counter is 8 bits. len=255 gives 256 beats with no wrap before the exit.
- Addresses are passed unchanged. The master neither checks nor splits at 4 KB boundaries, which is the client's responsibility.

## Timing
- Reset (async assert, sync release): state IDLE, cmd_ready=1.
  - All of AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY, rd_valid, rd_last, wd_ready, done and len_err are 0.
  - done_resp=0, address/len registers 0, counter 0.
- Command accepted at edge N: AWVALID/ARVALID is high in cycle N+1. VALID is held stable with constant address/len until READY.
- READY may already be high when VALID rises. Address handshake completes in the same cycle, and W/R channel handling starts in the next cycle.
- Best-case write of L+1 beats: AW 1 cycle, W L+1 cycles, B ≥1 cycle. done is asserted the cycle after the B handshake.
- Best-case read: AR 1 cycle, R L+1 cycles. done is asserted the cycle after the final beat.
- cmd_ready=0 from acceptance through the DONE cycle. The next command can be accepted the cycle after done.
- No WVALID before the AW handshake. BREADY is asserted only in state B.
- Stalls: wd_valid=0 or WREADY=0 holds the counter. rd_ready=0 holds RREADY low, and RDATA must be held by the responder.
- Stray BVALID/RVALID outside B/R is ignored (ready low).
- Reset mid-burst aborts immediately to the reset values, with no done pulse.

## Test plan
- Single write: cmd write addr 0x0010, len 0, wd_data 0xDEADBEEF, responder ready immediately.
  - Expect AWVALID at N+1 with AWLEN=0, AWSIZE=2.
  - Expect one W beat with WLAST=1, then BREADY.
  - Expect done with done_resp=0.
- Burst write: len 3, data 0x11..0x44, WREADY low on alternate cycles.
  - Expect exactly 4 W beats in order, WLAST on the 4th only.
  - Expect done after the B handshake.
- Burst read: read addr 0x0010, len 3, rd_ready low for 2 cycles mid-burst.
  - Expect rd_data returned in order, RREADY tracking rd_ready, rd_last on beat 4.
  - Expect done with done_resp=0 and len_err=0.
- Delayed address ready: AWREADY held low 5 cycles.
  - Expect AWVALID/AWADDR stable throughout and WVALID=0 until after the handshake.
  - Expect the same check for ARVALID with ARREADY held low.
- Errors:
  - Read len 3 with RLAST on beat 2: exit after beat 2, done with len_err=1.
  - Read with RRESP=2 on one beat: done_resp=2.
  - Write with BRESP=3: done_resp=3.
- Reset: assert ARESET during beat 2 of a len-7 write.
  - Expect all outputs at reset values immediately and no done pulse.
  - Expect a new command accepted normally after release.

Source files
------------

// File: rtl/axi4_master.sv
// AXI4 initiator: one command in, one INCR burst out on AW/W/B or AR/R.
// Reports completion with a one-cycle done pulse and the final response.
//
// Ports:
//   ACLK, ARESET                 clock, async active-high reset
//   cmd_*                        command handshake (write flag, addr, len)
//   wd_*                         write-data stream from the client
//   rd_*                         read-data stream to the client
//   done, done_resp, len_err     completion pulse, response, length error
//   AW*/W*/B*/AR*/R*             AXI4 master channels (no IDs, no WSTRB)
module axi4_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  len_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  last;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign last      = (cnt_q == len_q);
  assign AWADDR    = addr_q;
  assign AWLEN     = len_q;
  assign AWSIZE    = SIZE;
  assign ARADDR    = addr_q;
  assign ARLEN     = len_q;
  assign ARSIZE    = SIZE;
  assign done_resp = resp_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    WDATA     = '0;
    wd_ready  = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    rd_data   = '0;
    done      = 1'b0;
    len_err   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = '0;
          resp_d  = '0;
          err_d   = 1'b0;
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_d = S_W;
      end
      S_W: begin
        WVALID   = wd_valid;
        WDATA    = wd_data;
        WLAST    = last;
        wd_ready = WREADY;
        if (wd_valid && WREADY) begin
          cnt_d = cnt_q + 8'd1;
          if (last) state_d = S_B;
        end
      end
      S_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          resp_d  = BRESP;
          state_d = S_DONE;
        end
      end
      S_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = S_R;
      end
      S_R: begin
        rd_valid = RVALID;
        rd_data  = RDATA;
        rd_last  = RLAST;
        RREADY   = rd_ready;
        if (RVALID && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (RRESP > resp_q) resp_d = RRESP;
          // Early RLAST and missing RLAST are both length errors.
          if (RLAST != last) err_d = 1'b1;
          if (RLAST || last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        len_err = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_master.sv
// Directed bench for axi4_master: writes, reads, stalls, errors, reset.
// Acts as the AXI responder and the command/stream client.
module tb_axi4_master;

  logic        ACLK;
  logic        ARESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wd_data;
  logic        wd_valid;
  logic        wd_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic        len_err;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WLAST;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [15:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RLAST;
  logic        RREADY;

  int vec;
  int miss;
  logic [31:0] wdat [256];
  logic [31:0] rdat [256];

  axi4_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .len_err(len_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST),
    .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    vec++;
    assert (o === e) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wd_data = 0; wd_valid = 0; rd_ready = 0;
    AWREADY = 0; WREADY = 0; BRESP = 0; BVALID = 0;
    ARREADY = 0; RDATA = 0; RRESP = 0; RVALID = 0; RLAST = 0;
  endtask

  task automatic issue(input bit w, input logic [15:0] a,
                       input logic [7:0] l);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    step();
    cmd_valid = 0; cmd_addr = 16'hFFFF; cmd_len = 8'hFF;
  endtask

  task automatic wr_txn(input logic [15:0] a, input logic [7:0] l,
                        input int aw_wait, input bit alt,
                        input logic [1:0] br);
    int beat;
    int cyc;
    issue(1'b1, a, l);
    for (int i = 0; i < aw_wait; i++) begin
      AWREADY = 0; wd_valid = 1; wd_data = wdat[0]; WREADY = 1;
      #1;
      chk("aw_hold_valid", AWVALID, 1);
      chk("aw_hold_addr", AWADDR, a);
      chk("aw_hold_len", AWLEN, l);
      chk("w_before_aw", WVALID, 0);
      chk("wd_ready_before_aw", wd_ready, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      step();
    end
    AWREADY = 1;
    #1;
    chk("awvalid", AWVALID, 1);
    chk("awaddr", AWADDR, a);
    chk("awlen", AWLEN, l);
    chk("awsize", AWSIZE, 2);
    chk("arvalid_on_write", ARVALID, 0);
    step();
    AWREADY = 0;
    beat = 0;
    cyc = 0;
    while (beat <= int'(l) && cyc < 600) begin
      wd_valid = 1;
      wd_data = wdat[beat];
      WREADY = alt ? (cyc % 2 == 1) : 1'b1;
      #1;
      chk("wvalid", WVALID, 1);
      chk("wdata", WDATA, wdat[beat]);
      chk("wlast", WLAST, beat == int'(l));
      chk("wd_ready", wd_ready, WREADY);
      chk("bready_in_w", BREADY, 0);
      if (WREADY) beat++;
      cyc++;
      step();
    end
    chk("w_beats", beat, int'(l) + 1);
    wd_valid = 0; WREADY = 0;
    #1;
    chk("wvalid_after", WVALID, 0);
    chk("bready", BREADY, 1);
    chk("no_done_before_b", done, 0);
    step();
    BVALID = 1; BRESP = br;
    #1;
    chk("bready_hs", BREADY, 1);
    step();
    BVALID = 0; BRESP = 0;
    #1;
    chk("w_done", done, 1);
    chk("w_done_resp", done_resp, br);
    chk("w_len_err", len_err, 0);
    chk("w_cmd_ready_done", cmd_ready, 0);
    step();
    chk("w_done_pulse", done, 0);
    chk("w_cmd_ready_after", cmd_ready, 1);
  endtask

  task automatic rd_txn(input logic [15:0] a, input logic [7:0] l,
                        input int ar_wait, input int stall_at,
                        input int rlast_at, input int rr_at,
                        input logic [1:0] rr, input logic [1:0] exp_resp,
                        input bit exp_err);
    int beat;
    int cyc;
    int stalls;
    int eb;
    bit fin;
    eb = (rlast_at < int'(l)) ? rlast_at + 1 : int'(l) + 1;
    issue(1'b0, a, l);
    for (int i = 0; i < ar_wait; i++) begin
      ARREADY = 0; RVALID = 1; rd_ready = 1;
      #1;
      chk("ar_hold_valid", ARVALID, 1);
      chk("ar_hold_addr", ARADDR, a);
      chk("ar_hold_len", ARLEN, l);
      chk("rready_before_ar", RREADY, 0);
      chk("rd_valid_before_ar", rd_valid, 0);
      step();
    end
    ARREADY = 1; RVALID = 0;
    #1;
    chk("arvalid", ARVALID, 1);
    chk("araddr", ARADDR, a);
    chk("arlen", ARLEN, l);
    chk("arsize", ARSIZE, 2);
    chk("awvalid_on_read", AWVALID, 0);
    step();
    ARREADY = 0;
    beat = 0; cyc = 0; stalls = 0; fin = 0;
    while (!fin && cyc < 600) begin
      RVALID = 1;
      RDATA = rdat[beat];
      RLAST = (beat == rlast_at);
      RRESP = (beat == rr_at) ? rr : 2'd0;
      rd_ready = 1;
      if (beat == stall_at && stalls < 2) rd_ready = 0;
      #1;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, rdat[beat]);
      chk("rready", RREADY, rd_ready);
      chk("rd_last", rd_last, beat == rlast_at);
      chk("r_no_done", done, 0);
      if (rd_ready) begin
        if (beat == rlast_at || beat == int'(l)) fin = 1;
        beat++;
      end else begin
        stalls++;
      end
      cyc++;
      step();
    end
    chk("r_beats", beat, eb);
    RVALID = 0; RLAST = 0; RRESP = 0; rd_ready = 0;
    #1;
    chk("r_done", done, 1);
    chk("r_done_resp", done_resp, exp_resp);
    chk("r_len_err", len_err, exp_err);
    chk("r_rready_done", RREADY, 0);
    chk("r_cmd_ready_done", cmd_ready, 0);
    step();
    chk("r_done_pulse", done, 0);
    chk("r_len_err_after", len_err, 0);
    chk("r_cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    vec = 0;
    miss = 0;
    for (int i = 0; i < 256; i++) begin
      wdat[i] = 32'h5A000000 + i;
      rdat[i] = 32'hC0DE0000 + i * 3;
    end
    idle_inputs();
    ARESET = 1;
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wlast", WLAST, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_wd_ready", wd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_done_resp", done_resp, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_arlen", ARLEN, 0);
    step();
    step();
    ARESET = 0;
    step();

    BVALID = 1; RVALID = 1; RLAST = 1;
    #1;
    chk("stray_bready", BREADY, 0);
    chk("stray_rready", RREADY, 0);
    chk("stray_rd_valid", rd_valid, 0);
    chk("stray_rd_last", rd_last, 0);
    step();
    chk("stray_no_done", done, 0);
    BVALID = 0; RVALID = 0; RLAST = 0;

    wdat[0] = 32'hDEADBEEF;
    wr_txn(16'h0010, 8'd0, 0, 1'b0, 2'd0);

    wdat[0] = 32'h11; wdat[1] = 32'h22;
    wdat[2] = 32'h33; wdat[3] = 32'h44;
    wr_txn(16'h0020, 8'd3, 0, 1'b1, 2'd0);

    rdat[0] = 32'hA0A0A0A0; rdat[1] = 32'hB1B1B1B1;
    rdat[2] = 32'hC2C2C2C2; rdat[3] = 32'hD3D3D3D3;
    rd_txn(16'h0010, 8'd3, 0, 2, 3, -1, 2'd0, 2'd0, 1'b0);

    wr_txn(16'h0400, 8'd1, 5, 1'b0, 2'd0);
    rd_txn(16'h0800, 8'd1, 5, -1, 1, -1, 2'd0, 2'd0, 1'b0);

    rd_txn(16'h0030, 8'd3, 0, -1, 1, -1, 2'd0, 2'd0, 1'b1);
    rd_txn(16'h0040, 8'd1, 0, -1, 99, -1, 2'd0, 2'd0, 1'b1);
    rd_txn(16'h0050, 8'd3, 0, -1, 3, 1, 2'd2, 2'd2, 1'b0);
    wr_txn(16'h0060, 8'd2, 0, 1'b0, 2'd3);
    rd_txn(16'h1000, 8'd255, 0, -1, 255, 200, 2'd1, 2'd1, 1'b0);

    issue(1'b1, 16'h0200, 8'd7);
    AWREADY = 1;
    #1;
    chk("rstw_awvalid", AWVALID, 1);
    step();
    AWREADY = 0;
    wd_valid = 1; wd_data = 32'h01; WREADY = 1;
    #1;
    chk("rstw_beat1", WVALID, 1);
    step();
    wd_data = 32'h02;
    #1;
    chk("rstw_beat2", WVALID, 1);
    ARESET = 1;
    #1;
    chk("rstw_wvalid", WVALID, 0);
    chk("rstw_wlast", WLAST, 0);
    chk("rstw_wd_ready", wd_ready, 0);
    chk("rstw_awvalid0", AWVALID, 0);
    chk("rstw_bready", BREADY, 0);
    chk("rstw_cmd_ready", cmd_ready, 1);
    chk("rstw_done", done, 0);
    chk("rstw_awaddr", AWADDR, 0);
    chk("rstw_awlen", AWLEN, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rstw_no_done", done, 0);
    end
    wd_valid = 0; WREADY = 0;
    ARESET = 0;
    step();
    chk("rstw_idle_done", done, 0);
    wdat[0] = 32'hFACEFEED;
    wr_txn(16'h0300, 8'd0, 0, 1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
